// File: rtl/nmx1_pkg.sv
// Shared types and constants for the NEUROMORPHIC_X1 bus initiator.
// The ERR state exists only when NMX1_TIMEOUT_EN is defined.
package nmx1_pkg;

  localparam int NMX1_DW = 32;
  localparam int NMX1_AW = 32;
  localparam int NMX1_SW = 4;

  localparam logic NMX1_RWB_READ  = 1'b1;
  localparam logic NMX1_RWB_WRITE = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP,
    ST_DRAIN
`ifdef NMX1_TIMEOUT_EN
    , ST_ERR
`endif
  } nmx1_init_state_e;

endpackage

// File: rtl/nmx1_timeout_ctr.sv
// Cycle counter bounding how long EN may stay high without func_ack.
// Used only when NMX1_TIMEOUT_EN is defined.
module nmx1_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   cnt <= '0;
    else if (clr)              cnt <= '0;
    else if (run && !expired)  cnt <= cnt + 1'b1;
  end

  // Fires during the TIMEOUT_CYCLES-th EN cycle so EN drops right after it.
  assign expired = run && (cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/nmx1_bus_initiator.sv
// Wishbone-classic slave to NEUROMORPHIC_X1 macro port initiator.
// Optional EN watchdog and wb_err response enabled by NMX1_TIMEOUT_EN.
module nmx1_bus_initiator
  import nmx1_pkg::*;
#(
  parameter int                 TIMEOUT_CYCLES = 255,
  parameter logic [NMX1_DW-1:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic               CLKin,
  input  logic               RSTin,
  input  logic               wb_cyc_i,
  input  logic               wb_stb_i,
  input  logic               wb_we_i,
  input  logic [NMX1_AW-1:0] wb_adr_i,
  input  logic [NMX1_DW-1:0] wb_dat_i,
  input  logic [NMX1_SW-1:0] wb_sel_i,
  output logic [NMX1_DW-1:0] wb_dat_o,
  output logic               wb_ack_o,
  output logic               wb_err_o,
  output logic               EN,
  output logic               R_WB,
  output logic [NMX1_DW-1:0] DI,
  output logic [NMX1_AW-1:0] AD,
  output logic [NMX1_SW-1:0] SEL,
  input  logic [NMX1_DW-1:0] DO,
  input  logic               func_ack,
  output logic               busy_o,
  output logic               spur_ack_o
);

  nmx1_init_state_e state_q, state_d;
  logic             en_d;
  logic             load;
  logic             cap;
  logic             expired;
  logic [NMX1_DW-1:0] dat_q;

`ifdef NMX1_TIMEOUT_EN
  logic from_drain_q;
  logic err_vis;

  nmx1_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_to (
    .clk     (CLKin),
    .rst     (RSTin),
    .clr     (state_q == ST_IDLE),
    .run     ((state_q == ST_WAIT) || (state_q == ST_DRAIN)),
    .expired (expired)
  );

  // An abandoned transfer that times out must stay silent on the bus.
  always_ff @(posedge CLKin or posedge RSTin) begin
    if (RSTin) from_drain_q <= 1'b0;
    else       from_drain_q <= (state_q == ST_DRAIN);
  end

  assign err_vis  = (state_q == ST_ERR) && !from_drain_q;
  assign wb_err_o = err_vis;
  assign wb_dat_o = err_vis ? ERR_DATA : dat_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^{ERR_DATA, TIMEOUT_CYCLES[0]};
  assign expired    = 1'b0;
  assign wb_err_o   = 1'b0;
  assign wb_dat_o   = dat_q;
`endif

  assign wb_ack_o = (state_q == ST_RESP);
  assign busy_o   = (state_q != ST_IDLE);

  always_ff @(posedge CLKin or posedge RSTin) begin
    if (RSTin) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    en_d    = EN;
    load    = 1'b0;
    cap     = 1'b0;
    unique case (state_q)
      ST_IDLE: if (wb_cyc_i && wb_stb_i) begin
        load    = 1'b1;
        en_d    = 1'b1;
        state_d = ST_WAIT;
      end
      // Completion wins over a simultaneous cyc drop or timeout.
      ST_WAIT: if (func_ack) begin
        en_d    = 1'b0;
        cap     = (R_WB == NMX1_RWB_READ);
        state_d = ST_RESP;
      end else if (expired) begin
        en_d    = 1'b0;
`ifdef NMX1_TIMEOUT_EN
        state_d = ST_ERR;
`else
        state_d = ST_IDLE;
`endif
      end else if (!wb_cyc_i) begin
        state_d = ST_DRAIN;
      end
      ST_DRAIN: if (func_ack) begin
        en_d    = 1'b0;
        state_d = ST_IDLE;
      end else if (expired) begin
        en_d    = 1'b0;
`ifdef NMX1_TIMEOUT_EN
        state_d = ST_ERR;
`else
        state_d = ST_IDLE;
`endif
      end
      ST_RESP: state_d = ST_IDLE;
`ifdef NMX1_TIMEOUT_EN
      ST_ERR:  state_d = ST_IDLE;
`endif
      default: begin
        en_d    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLKin or posedge RSTin) begin
    if (RSTin) begin
      EN         <= 1'b0;
      R_WB       <= 1'b0;
      AD         <= '0;
      DI         <= '0;
      SEL        <= '0;
      dat_q      <= '0;
      spur_ack_o <= 1'b0;
    end else begin
      EN <= en_d;
      if (load) begin
        R_WB <= wb_we_i ? NMX1_RWB_WRITE : NMX1_RWB_READ;
        AD   <= wb_adr_i;
        DI   <= wb_dat_i;
        SEL  <= wb_sel_i;
      end
      if (cap) dat_q <= DO;
      if (func_ack && !EN) spur_ack_o <= 1'b1;
    end
  end

endmodule
